// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_ctrl_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  // Lowest-index row that reads low; the caller guarantees at least one does.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer; resets to all-ones so idle active-low inputs read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: column sequencing, press/release debounce,
// and a valid/ready key output with overrun signalling.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);
  localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [NUM_ROWS-1:0] w_rows_s;
  logic                w_row_bit;
  logic                w_accept;
  state_e              r_state, w_state_next;
  logic [1:0]          r_col, w_col_next;
  logic [1:0]          r_row, w_row_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [KEY_W-1:0]    r_key_code, w_key_code_next;
  logic                r_key_valid, w_key_valid_next;
  logic                r_key_held, w_key_held_next;
  logic                r_overrun, w_overrun_next;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (row_i),
    .o_q   (w_rows_s)
  );

  assign w_row_bit = w_rows_s[r_row];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_cnt       <= w_cnt_next;
      r_key_code  <= w_key_code_next;
      r_key_valid <= w_key_valid_next;
      r_key_held  <= w_key_held_next;
      r_overrun   <= w_overrun_next;
    end
  end

  // The counter is cleared on every terminal-count transition, so it never passes it.
  always_comb begin
    w_state_next    = r_state;
    w_col_next      = r_col;
    w_row_next      = r_row;
    w_cnt_next      = r_cnt;
    w_key_held_next = r_key_held;
    w_accept        = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_cnt >= SCAN_LAST) begin
          w_cnt_next = '0;
          if (!(&w_rows_s)) begin
            w_row_next   = lowest_low(w_rows_s);
            w_state_next = PRESS_DB;
          end else begin
            w_col_next = r_col + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESS_DB: begin
        if (w_row_bit) begin
          w_cnt_next   = '0;
          w_col_next   = r_col + 2'd1;
          w_state_next = SCAN;
        end else if (r_cnt >= DB_LAST) begin
          w_cnt_next      = '0;
          w_accept        = 1'b1;
          w_key_held_next = 1'b1;
          w_state_next    = HELD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      HELD: begin
        w_cnt_next = '0;
        if (w_row_bit) w_state_next = REL_DB;
      end
      REL_DB: begin
        if (!w_row_bit) begin
          w_cnt_next   = '0;
          w_state_next = HELD;
        end else if (r_cnt >= DB_LAST) begin
          w_cnt_next      = '0;
          w_key_held_next = 1'b0;
          w_col_next      = r_col + 2'd1;
          w_state_next    = SCAN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = SCAN;
    endcase
  end

  // A new key may replace one that is being consumed this same cycle.
  always_comb begin
    w_key_code_next  = r_key_code;
    w_key_valid_next = r_key_valid && !key_ready;
    w_overrun_next   = 1'b0;
    if (w_accept) begin
      if (!r_key_valid || key_ready) begin
        w_key_code_next  = {r_row, r_col};
        w_key_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end
  end

  assign col_o     = ~(NUM_COLS'(1) << r_col);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model closes the row/column loop,
// directed scenarios plus randomized presses are scored against expected key lists.
module tb_keypad_scan_ctrl;
  localparam int SCAN    = 4;
  localparam int DEB     = 8;
  localparam int LAT_MAX = 2 + 4 * SCAN + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overrun;

  logic [3:0] pressed [4];
  int         tests = 0;
  int         fails = 0;
  int         ovr_cnt = 0;
  int         got_q[$];
  int         exp_q[$];
  bit         rand_ready = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_TICKS(SCAN), .DEBOUNCE_TICKS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // A row reads low when any pressed switch on it sits on a driven (low) column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_i[r] = ~|(pressed[r] & ~col_o);
  end

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      got_q.push_back(int'(key_code));
      $display("[TB] key %0d delivered at %0t", key_code, $time);
    end
    if (rst_n && overrun) begin
      ovr_cnt++;
      $display("[TB] overrun pulse at %0t", $time);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] onecold(input int c);
    return ~(4'b0001 << c);
  endfunction

  function automatic int last_key();
    return (got_q.size() > 0) ? got_q[$] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) key_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_held(input logic v, input int max);
    int n = 0;
    while (key_held !== v && n < max) begin step(); n++; end
    check("wait_key_held", key_held, v);
  endtask

  task automatic wait_col(input int c, input int max);
    int n = 0;
    while (col_o === onecold(c) && n < max) begin step(); n++; end
    while (col_o !== onecold(c) && n < max) begin step(); n++; end
    check("wait_col", col_o, onecold(c));
  endtask

  task automatic wait_keys(input int cnt, input int max);
    int n = 0;
    while (got_q.size() < cnt && n < max) begin step(); n++; end
    check("key_count", got_q.size(), cnt);
  endtask

  initial begin
    int n;
    int q0;
    int o0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

    // Reset state and free-running column sequence
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col_o, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_code", key_code, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      check("col_step", col_o, onecold((i / 4) % 4));
      step();
    end

    // Clean press of key 9 (row 2, col 1)
    key_ready = 1'b1;
    wait_col(1, 40);
    pressed[2][1] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 60) begin step(); n++; end
    check("press9_valid", key_valid, 1'b1);
    check("press9_code", key_code, 4'd9);
    check("press9_latency", (n <= LAT_MAX), 1'b1);
    repeat (40 - n) step();
    check("press9_count", got_q.size(), 1);
    check("press9_key", last_key(), 9);
    check("press9_held", key_held, 1'b1);
    pressed[2][1] = 1'b0;
    n = 0;
    while (key_held === 1'b1 && n < 40) begin step(); n++; end
    check("release9_window", (n >= DEB && n <= DEB + 4), 1'b1);
    check("release9_next_col", col_o, onecold(2));

    // Bounce on row 0 / col 3, then a stable press
    wait_col(3, 40);
    pressed[0][3] = 1'b1;
    repeat (5) step();
    pressed[0][3] = 1'b0;
    n = 0;
    while (col_o === onecold(3) && n < 20) begin step(); n++; end
    check("bounce_resume_col", col_o, onecold(0));
    repeat (20) step();
    check("bounce_no_key", got_q.size(), 1);
    pressed[0][3] = 1'b1;
    wait_keys(2, 80);
    check("stable3_key", last_key(), 3);
    pressed[0][3] = 1'b0;
    wait_held(1'b0, 40);

    // Backpressure: key 5 pending while key 10 is accepted
    key_ready = 1'b0;
    pressed[1][1] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 60) begin step(); n++; end
    check("bp5_valid", key_valid, 1'b1);
    check("bp5_code", key_code, 4'd5);
    pressed[1][1] = 1'b0;
    wait_held(1'b0, 40);
    o0 = ovr_cnt;
    q0 = got_q.size();
    pressed[2][2] = 1'b1;
    wait_held(1'b1, 60);
    step();
    check("bp_overrun_once", ovr_cnt - o0, 1);
    check("bp_valid_kept", key_valid, 1'b1);
    check("bp_code_kept", key_code, 4'd5);
    pressed[2][2] = 1'b0;
    wait_held(1'b0, 40);
    repeat (5) step();
    check("bp_overrun_total", ovr_cnt - o0, 1);
    key_ready = 1'b1;
    step();
    check("bp_valid_drop", key_valid, 1'b0);
    check("bp_delivered", got_q.size(), q0 + 1);
    check("bp_delivered_key", last_key(), 5);

    // Simultaneous rows 1 and 3 on col 0, then row 3 alone
    q0 = got_q.size();
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    wait_keys(q0 + 1, 80);
    check("multi_first", last_key(), 4);
    pressed[1][0] = 1'b0;
    wait_keys(q0 + 2, 120);
    check("multi_second", last_key(), 12);
    pressed[3][0] = 1'b0;
    wait_held(1'b0, 40);

    // Reset asserted during press debounce
    wait_col(1, 40);
    pressed[0][1] = 1'b1;
    repeat (SCAN + 3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_col", col_o, 4'b1110);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_held", key_held, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_code", key_code, 4'd0);
    pressed[0][1] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    q0 = got_q.size();
    repeat (40) step();
    check("midrst_no_key", got_q.size(), q0);
    check("midrst_no_held", key_held, 1'b0);
    pressed[3][3] = 1'b1;
    wait_keys(q0 + 1, 80);
    check("fresh_key", last_key(), 15);
    pressed[3][3] = 1'b0;
    wait_held(1'b0, 40);

    // Randomized presses with random consumer readiness
    q0 = got_q.size();
    o0 = ovr_cnt;
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int r;
      int c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      exp_q.push_back(r * 4 + c);
      pressed[r][c] = 1'b1;
      repeat ($urandom_range(LAT_MAX + 4, 50)) step();
      check("rand_held", key_held, 1'b1);
      pressed[r][c] = 1'b0;
      repeat ($urandom_range(DEB + 8, 30)) step();
      check("rand_released", key_held, 1'b0);
    end
    rand_ready = 1'b0;
    key_ready = 1'b1;
    repeat (4) step();
    check("rand_count", got_q.size() - q0, exp_q.size());
    check("rand_overrun", ovr_cnt - o0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      check("rand_key", (q0 + k < got_q.size()) ? got_q[q0 + k] : -1, exp_q[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
